// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared constants and lane state type for the SN operand deframer
//
// SN_DATA_W           operand width, matches the SN comparator width
// SN_EPOCH_LEN        length of one accumulation window in clock cycles
// sn_deframe_state_t  per-lane receive state
package sn_pkg;

  localparam int SN_DATA_W    = 9;
  localparam int SN_EPOCH_LEN = 131073;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } sn_deframe_state_t;

endpackage

// File: rtl/sn_operand_deframer_if.sv
// rtl/sn_operand_deframer_if.sv - operand deframer bus: serial lines, epoch tick, committed operands and status pulses
//
// master: drives ser_in_1/ser_in_2/epoch_tick, observes operands and status
// slave : the deframer; consumes the serial lines and tick, drives operands and status
interface sn_operand_deframer_if #(
  parameter int DATA_W = 9
);

  logic              ser_in_1;
  logic              ser_in_2;
  logic              epoch_tick;
  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic              operands_valid;
  logic              frame_err_1;
  logic              frame_err_2;
  logic              overrun_1;
  logic              overrun_2;

  modport master (
    output ser_in_1, ser_in_2, epoch_tick,
    input  operand_1, operand_2, operands_valid,
    input  frame_err_1, frame_err_2, overrun_1, overrun_2
  );

  modport slave (
    input  ser_in_1, ser_in_2, epoch_tick,
    output operand_1, operand_2, operands_valid,
    output frame_err_1, frame_err_2, overrun_1, overrun_2
  );

endinterface

// File: rtl/sn_deframe_lane.sv
// rtl/sn_deframe_lane.sv - one serial lane: frame FSM, shift register, pending word and error pulses
//
// Optional feature macro: SN_DEFRAME_PARITY_EN (even parity bit between data and stop).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_ser         serial line, one bit per clock, idles high
//   i_commit      epoch tick; the top copies o_pending out in this cycle when o_pend_flag is set
//   o_pending     last good word received
//   o_pend_flag   o_pending holds a word not yet committed
//   o_frame_err   one-cycle pulse after a rejected frame
//   o_overrun     one-cycle pulse after a good frame replaced an uncommitted word
module sn_deframe_lane
  import sn_pkg::*;
#(
  parameter int DATA_W = SN_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ser,
  input  logic              i_commit,
  output logic [DATA_W-1:0] o_pending,
  output logic              o_pend_flag,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  sn_deframe_state_t r_state;
  sn_deframe_state_t w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_pending;
  logic              r_pend_flag;
  logic              r_frame_err;
  logic              r_overrun;
  logic              w_last_bit;
  logic              w_par_ok;
  logic              w_good_stop;
  logic              w_bad_stop;

`ifdef SN_DEFRAME_PARITY_EN
  logic r_par_ok;
  assign w_par_ok = r_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_good_stop = 1'b0;
    w_bad_stop  = 1'b0;
    case (r_state)
      IDLE:   if (!i_ser) w_state_nxt = DATA;
      DATA: begin
        if (w_last_bit) begin
`ifdef SN_DEFRAME_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
      PARITY: w_state_nxt = STOP;
      STOP: begin
        if (i_ser && w_par_ok) begin
          w_good_stop = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_bad_stop  = 1'b1;
          w_state_nxt = BREAK;
        end
      end
      // Only a high bit re-arms start detection, so a stuck-low line never resynchronises.
      BREAK:  if (i_ser) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SN_DEFRAME_PARITY_EN
      r_par_ok    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_bad_stop;
      // A word pending on an epoch edge is committed on that same edge, so it is not lost.
      r_overrun   <= w_good_stop & r_pend_flag & ~i_commit;
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (r_state == DATA) begin
        // LSB arrives first: shift right so bit 0 ends at position 0.
        r_shift <= {i_ser, r_shift[DATA_W-1:1]};
        r_cnt   <= r_cnt + 1'b1;
      end
`ifdef SN_DEFRAME_PARITY_EN
      if (r_state == PARITY) r_par_ok <= ~((^r_shift) ^ i_ser);
`endif
      if (w_good_stop) begin
        r_pending   <= r_shift;
        r_pend_flag <= 1'b1;
      end else if (i_commit) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  assign o_pending   = r_pending;
  assign o_pend_flag = r_pend_flag;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/sn_operand_deframer.sv
// rtl/sn_operand_deframer.sv - two-lane serial operand deframer with epoch-aligned operand commit
//
// Optional feature macro: SN_DEFRAME_PARITY_EN (passed through to both lanes).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of sn_operand_deframer_if: serial lines and epoch tick in,
//               committed operands, operands_valid and per-lane status pulses out
module sn_operand_deframer
  import sn_pkg::*;
#(
  parameter int DATA_W = SN_DATA_W
) (
  input logic                  clk,
  input logic                  rst_n,
  sn_operand_deframer_if.slave bus
);

  logic [DATA_W-1:0] w_pending_1;
  logic [DATA_W-1:0] w_pending_2;
  logic              w_pend_flag_1;
  logic              w_pend_flag_2;
  logic [DATA_W-1:0] r_operand_1;
  logic [DATA_W-1:0] r_operand_2;
  logic              r_committed_1;
  logic              r_committed_2;

  sn_deframe_lane #(.DATA_W(DATA_W)) u_lane_1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ser       (bus.ser_in_1),
    .i_commit    (bus.epoch_tick),
    .o_pending   (w_pending_1),
    .o_pend_flag (w_pend_flag_1),
    .o_frame_err (bus.frame_err_1),
    .o_overrun   (bus.overrun_1)
  );

  sn_deframe_lane #(.DATA_W(DATA_W)) u_lane_2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ser       (bus.ser_in_2),
    .i_commit    (bus.epoch_tick),
    .o_pending   (w_pending_2),
    .o_pend_flag (w_pend_flag_2),
    .o_frame_err (bus.frame_err_2),
    .o_overrun   (bus.overrun_2)
  );

  // Operands only move on the window boundary; a lane with nothing pending keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand_1   <= '0;
      r_operand_2   <= '0;
      r_committed_1 <= 1'b0;
      r_committed_2 <= 1'b0;
    end else if (bus.epoch_tick) begin
      if (w_pend_flag_1) begin
        r_operand_1   <= w_pending_1;
        r_committed_1 <= 1'b1;
      end
      if (w_pend_flag_2) begin
        r_operand_2   <= w_pending_2;
        r_committed_2 <= 1'b1;
      end
    end
  end

  assign bus.operand_1      = r_operand_1;
  assign bus.operand_2      = r_operand_2;
  assign bus.operands_valid = r_committed_1 & r_committed_2;

endmodule

// File: tb/tb_sn_operand_deframer.sv
// tb/tb_sn_operand_deframer.sv - frame-level model bench for sn_operand_deframer (directed + random frames)
module tb_sn_operand_deframer;

  localparam int W    = 9;
  localparam int NCYC = 3000;
`ifdef SN_DEFRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sn_operand_deframer_if #(.DATA_W(W)) bus ();
  sn_operand_deframer #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Stimulus schedule, indexed by the clock edge that samples it.
  logic         bits    [2][NCYC];
  bit           ep      [NCYC];
  bit           rst_a   [NCYC];
  int           ev_kind [2][NCYC];   // 1 = good stop sampled here, 2 = rejected frame
  logic [W-1:0] ev_word [2][NCYC];

  // Expected outputs just after each edge, and what the DUT showed.
  logic [W-1:0] exp_op [2][NCYC];
  bit           exp_vld[NCYC];
  bit           exp_fe [2][NCYC];
  bit           exp_ov [2][NCYC];
  logic [W-1:0] act_op [2][NCYC];
  logic         act_vld[NCYC];
  logic         act_fe [2][NCYC];
  logic         act_ov [2][NCYC];

  int n_cmp  = 0;
  int n_bad  = 0;
  int cur    = 0;
  bit run_en = 1'b0;

  function automatic int put_frame(input int l, input int s, input logic [W-1:0] w,
                                   input bit stop_b, input bit par_flip);
    int p;
    p = s;
    bits[l][p] = 1'b0;
    p++;
    for (int i = 0; i < W; i++) begin
      bits[l][p] = w[i];
      p++;
    end
    if (PAR != 0) begin
      bits[l][p] = (^w) ^ par_flip;
      p++;
    end
    bits[l][p]    = stop_b;
    ev_kind[l][p] = (stop_b && !par_flip) ? 1 : 2;
    ev_word[l][p] = w;
    return p + 1;
  endfunction

  // Low bits after a rejected frame, then one high bit that releases the lane.
  function automatic int put_break_exit(input int l, input int s, input int nzero);
    for (int i = 0; i < nzero; i++) bits[l][s+i] = 1'b0;
    return s + nzero + 1;
  endfunction

  // Frame-level behaviour: commit on epoch, then land the new word; report errors/overruns next cycle.
  task automatic build_model();
    logic [W-1:0] pw[2];
    logic [W-1:0] op[2];
    bit           pv[2];
    bit           cm[2];
    for (int l = 0; l < 2; l++) begin
      pw[l] = '0; op[l] = '0; pv[l] = 1'b0; cm[l] = 1'b0;
    end
    for (int c = 0; c < NCYC; c++) begin
      for (int l = 0; l < 2; l++) begin
        exp_fe[l][c] = 1'b0;
        exp_ov[l][c] = 1'b0;
        if (rst_a[c]) begin
          pw[l] = '0; op[l] = '0; pv[l] = 1'b0; cm[l] = 1'b0;
        end else begin
          if (ep[c] && pv[l]) begin
            op[l] = pw[l];
            cm[l] = 1'b1;
            pv[l] = 1'b0;
          end
          if (ev_kind[l][c] == 1) begin
            exp_ov[l][c] = pv[l];
            pw[l] = ev_word[l][c];
            pv[l] = 1'b1;
          end else if (ev_kind[l][c] == 2) begin
            exp_fe[l][c] = 1'b1;
          end
        end
        exp_op[l][c] = op[l];
      end
      exp_vld[c] = cm[0] & cm[1];
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (run_en) begin
      act_op[0][cur] = bus.operand_1;
      act_op[1][cur] = bus.operand_2;
      act_vld[cur]   = bus.operands_valid;
      act_fe[0][cur] = bus.frame_err_1;
      act_fe[1][cur] = bus.frame_err_2;
      act_ov[0][cur] = bus.overrun_1;
      act_ov[1][cur] = bus.overrun_2;
      n_cmp++;
      if ({bus.operand_1, bus.operand_2, bus.operands_valid, bus.frame_err_1, bus.frame_err_2,
           bus.overrun_1, bus.overrun_2} !==
          {exp_op[0][cur], exp_op[1][cur], exp_vld[cur], exp_fe[0][cur], exp_fe[1][cur],
           exp_ov[0][cur], exp_ov[1][cur]}) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got op1=%h op2=%h vld=%b fe=%b%b ov=%b%b, want op1=%h op2=%h vld=%b fe=%b%b ov=%b%b",
                 cur, bus.operand_1, bus.operand_2, bus.operands_valid, bus.frame_err_1,
                 bus.frame_err_2, bus.overrun_1, bus.overrun_2, exp_op[0][cur], exp_op[1][cur],
                 exp_vld[cur], exp_fe[0][cur], exp_fe[1][cur], exp_ov[0][cur], exp_ov[1][cur]);
      end
    end
  end

  initial begin
    int t, p, e1, e2, s3, q3, e3b, s4a, s4b, e4, s5, tr, er, rs, pos, r, k;
`ifdef SN_DEFRAME_PARITY_EN
    int sp, e6;
`endif
    bus.ser_in_1   = 1'b1;
    bus.ser_in_2   = 1'b1;
    bus.epoch_tick = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      bits[0][c] = 1'b1; bits[1][c] = 1'b1;
      ep[c] = 1'b0; rst_a[c] = 1'b0;
      ev_kind[0][c] = 0; ev_kind[1][c] = 0;
      ev_word[0][c] = '0; ev_word[1][c] = '0;
    end
    for (int c = 0; c < 4; c++) rst_a[c] = 1'b1;

    // One lane only committed: operand_2 stays 0, not yet valid.
    p  = put_frame(0, 8, 9'h1FF, 1'b1, 1'b0);
    e2 = p + 2; ep[e2] = 1'b1;
    // Both lanes framed, one epoch.
    t  = e2 + 3;
    p  = put_frame(0, t, 9'h155, 1'b1, 1'b0);
    p  = put_frame(1, t, 9'h0AA, 1'b1, 1'b0);
    e1 = p + 1; ep[e1] = 1'b1;
    // Bad stop, then a stuck-low stretch shaped like a 0x000 frame, which must be ignored.
    t  = e1 + 3;
    p  = put_frame(0, t, 9'h0F0, 1'b0, 1'b0);
    s3 = p - 1;
    p  = put_break_exit(0, p, W + 1);
    q3 = p + 1; ep[q3] = 1'b1;
    p  = put_frame(0, q3 + 2, 9'h0F0, 1'b1, 1'b0);
    e3b = p + 1; ep[e3b] = 1'b1;
    // Two back-to-back good frames on lane 2 before an epoch.
    t   = e3b + 3;
    p   = put_frame(1, t, 9'h010, 1'b1, 1'b0);
    s4a = p - 1;
    p   = put_frame(1, p, 9'h020, 1'b1, 1'b0);
    s4b = p - 1;
    e4  = p + 1; ep[e4] = 1'b1;
    // Stop bit and epoch on the same edge.
    t  = e4 + 3;
    p  = put_frame(0, t, 9'h033, 1'b1, 1'b0);
    p  = put_frame(0, p + 2, 9'h044, 1'b1, 1'b0);
    s5 = p - 1; ep[s5] = 1'b1; ep[s5+4] = 1'b1;
    t  = s5 + 7;
`ifdef SN_DEFRAME_PARITY_EN
    p  = put_frame(0, t, 9'h001, 1'b1, 1'b1);
    sp = p - 1;
    p  = put_frame(0, p + 1, 9'h001, 1'b1, 1'b0);
    e6 = p + 1; ep[e6] = 1'b1;
    t  = e6 + 3;
`endif
    // Reset in the middle of a lane-1 frame; line stays low into release and starts a new frame.
    tr = t;
    bits[0][tr] = 1'b0;
    for (int c = tr + 5; c < tr + 8; c++) begin
      rst_a[c] = 1'b1;
      bits[0][c] = 1'b0;
    end
    p  = put_frame(0, tr + 8, 9'h15A, 1'b1, 1'b0);
    er = p + 1; ep[er] = 1'b1;

    // Random traffic on both lanes with random epochs.
    rs = er + 4;
    for (int l = 0; l < 2; l++) begin
      pos = rs;
      while (pos < NCYC - 40) begin
        pos += $urandom_range(0, 3);
        r = $urandom_range(0, 9);
        if (r < 7) begin
          pos = put_frame(l, pos, W'($urandom_range(0, 511)), 1'b1, 1'b0);
        end else begin
          if (r == 9 && PAR != 0) pos = put_frame(l, pos, W'($urandom_range(0, 511)), 1'b1, 1'b1);
          else                    pos = put_frame(l, pos, W'($urandom_range(0, 511)), 1'b0, 1'b0);
          k   = $urandom_range(0, 2);
          pos = put_break_exit(l, pos, k);
        end
      end
    end
    for (int c = rs; c < NCYC; c++) ep[c] = ($urandom_range(0, 11) == 0);

    build_model();

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst_n          = !rst_a[c];
      bus.ser_in_1   = bits[0][c];
      bus.ser_in_2   = bits[1][c];
      bus.epoch_tick = ep[c];
      cur            = c;
      run_en         = 1'b1;
    end
    @(negedge clk);
    run_en = 1'b0;

    // Hand-computed anchors.
    lit("reset operand_1", {23'd0, act_op[0][2]}, 32'h0);
    lit("reset valid", {31'd0, act_vld[2]}, 32'h0);
    lit("model op1 lane1-only", {23'd0, exp_op[0][e2]}, 32'h1FF);
    lit("operand_1 before epoch edge", {23'd0, act_op[0][e2-1]}, 32'h0);
    lit("operand_1 lane1-only", {23'd0, act_op[0][e2]}, 32'h1FF);
    lit("operand_2 lane1-only", {23'd0, act_op[1][e2]}, 32'h0);
    lit("valid lane1-only", {31'd0, act_vld[e2]}, 32'h0);
    lit("model op2 both", {23'd0, exp_op[1][e1]}, 32'h0AA);
    lit("operand_1 both", {23'd0, act_op[0][e1]}, 32'h155);
    lit("operand_2 both", {23'd0, act_op[1][e1]}, 32'h0AA);
    lit("valid both", {31'd0, act_vld[e1]}, 32'h1);
    lit("frame_err_1 pulse", {31'd0, act_fe[0][s3]}, 32'h1);
    lit("frame_err_1 one cycle", {31'd0, act_fe[0][s3+1]}, 32'h0);
    lit("no commit after bad frame", {23'd0, act_op[0][q3]}, 32'h155);
    lit("recovered frame", {23'd0, act_op[0][e3b]}, 32'h0F0);
    lit("no overrun first frame", {31'd0, act_ov[1][s4a]}, 32'h0);
    lit("overrun_2 pulse", {31'd0, act_ov[1][s4b]}, 32'h1);
    lit("overrun_2 one cycle", {31'd0, act_ov[1][s4b+1]}, 32'h0);
    lit("overwritten word committed", {23'd0, act_op[1][e4]}, 32'h020);
    lit("coincident commit old word", {23'd0, act_op[0][s5]}, 32'h033);
    lit("coincident no overrun", {31'd0, act_ov[0][s5]}, 32'h0);
    lit("model coincident next epoch", {23'd0, exp_op[0][s5+4]}, 32'h044);
    lit("coincident next epoch", {23'd0, act_op[0][s5+4]}, 32'h044);
`ifdef SN_DEFRAME_PARITY_EN
    lit("parity error", {31'd0, act_fe[0][sp]}, 32'h1);
    lit("parity good accepted", {23'd0, act_op[0][e6]}, 32'h001);
`endif
    lit("mid-frame reset operand_1", {23'd0, act_op[0][tr+6]}, 32'h0);
    lit("mid-frame reset valid", {31'd0, act_vld[tr+6]}, 32'h0);
    lit("re-receive after reset", {23'd0, act_op[0][er]}, 32'h15A);
    lit("valid after reset lane1 only", {31'd0, act_vld[er]}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
